// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the data-cache tag-store controller.
package dcache_pkg;
  localparam int SIZE   = 128;
  localparam int IDX_W  = $clog2(SIZE);
  localparam int TAG_W  = 12;
  localparam int ADDR_W = TAG_W + IDX_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    FILL,
    WTHRU
  } state_t;

  // Request captured at grant time; stays frozen for the whole transaction.
  typedef struct packed {
    logic              tid;
    logic              we;
    logic [ADDR_W-1:0] addr;
  } req_t;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W+2];
  endfunction

  // Refill addresses drop the byte offset.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/dcache_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: the thread not granted last wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       nReset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  // prio_q = index of the thread preferred on a tie
  logic prio_q, prio_d;

  // Pick a winner and point priority at the loser
  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (advance) begin
      if (req == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
      else              grant = req;
    end
    if (grant[0])      prio_d = 1'b1;
    else if (grant[1]) prio_d = 1'b0;
  end

  // Priority pointer register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache tag-store sequencer: arbitration, lookup, refill and write-through.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters on hit_cnt/miss_cnt.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              nReset,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic              flush,
  output logic [1:0]        grant,
  output logic              resp_valid,
  output logic              resp_tid,
  output logic              resp_hit,
  output logic              ReadEnable,
  output logic [IDX_W-1:0]  CacheIndexRead,
  input  logic [TAG_W-1:0]  TagCompare,
  output logic              WriteTag,
  output logic [IDX_W-1:0]  CacheIndexWrite,
  output logic [TAG_W-1:0]  WriteAddressTag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  state_t            state_q, state_d;
  req_t              cur_q, cur_d;
  logic [SIZE-1:0]   valid_q, valid_d;
  logic              flush_pend_q, flush_pend_d;
  logic              hit_q, hit_d;
  logic              arb_en;
  logic [1:0]        arb_gnt;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic              lookup_hit;

  assign req_addr   = {req_addr1, req_addr0};
  assign cur_idx    = addr_idx(cur_q.addr);
  assign cur_tag    = addr_tag(cur_q.addr);
  assign lookup_hit = valid_q[cur_idx] && (TagCompare == cur_tag);
  assign grant      = arb_gnt;
  assign resp_tid   = resp_valid ? cur_q.tid : 1'b0;

  rr_arb2 u_arb (
    .clk     (clk),
    .nReset  (nReset),
    .req     (req),
    .advance (arb_en),
    .grant   (arb_gnt)
  );

  // Next-state and output decode; one transaction in flight at a time
  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    valid_d         = valid_q;
    flush_pend_d    = flush_pend_q;
    hit_d           = hit_q;
    arb_en          = 1'b0;
    ReadEnable      = 1'b0;
    CacheIndexRead  = '0;
    WriteTag        = 1'b0;
    CacheIndexWrite = '0;
    WriteAddressTag = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    resp_valid      = 1'b0;
    resp_hit        = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush cycle never grants, so the clear cannot race a lookup
        if (flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (|req) begin
          arb_en         = 1'b1;
          cur_d.tid      = arb_gnt[1];
          cur_d.we       = req_we[arb_gnt[1]];
          cur_d.addr     = req_addr[arb_gnt[1]];
          ReadEnable     = 1'b1;
          CacheIndexRead = addr_idx(cur_d.addr);
          state_d        = LOOKUP;
        end
      end
      LOOKUP: begin
        // TagCompare now holds the registered read issued at grant
        hit_d = lookup_hit;
        if (cur_q.we) begin
          state_d = WTHRU;
        end else if (lookup_hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = line_addr(cur_q.addr);
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        WriteTag         = 1'b1;
        CacheIndexWrite  = cur_idx;
        WriteAddressTag  = cur_tag;
        valid_d[cur_idx] = 1'b1;
        resp_valid       = 1'b1;
        state_d          = IDLE;
      end
      WTHRU: begin
        // No-allocate: tags and valid bits are left untouched
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cur_q.addr;
        if (mem_ack) begin
          resp_valid = 1'b1;
          resp_hit   = hit_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush arriving mid-transaction is deferred to the next IDLE cycle
    if (flush && state_q != IDLE) flush_pend_d = 1'b1;
  end

  // Controller state registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      hit_q        <= hit_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating lookup outcome counters, loads and stores alike
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule
